datapath: RTL and testbench

- 32-bit bus-based single-bus CPU datapath (Mini-SRC style) driven cycle by cycle by an external control unit or testbench through discrete control strobes.
- Contains:
  - 16 general registers R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO.
  - In/out port registers and a CON (branch condition) flip-flop.
  - ALU and a 512x32 internal RAM.
- Sits below the control unit; all transfers go over one shared 32-bit bus.

---
 rtl/datapath.sv | 264 ++++++++++++++++++++++++++
 tb/tb_datapath.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// datapath: 32-bit single-bus CPU datapath (Mini-SRC style). An external control unit drives
// one strobe per transfer. Every source drives the shared bus through a fixed-priority mux, and
// every register loads from it on the rising edge of Clock.
//
// Ports
//   Clock, clear          rising-edge clock; synchronous active-high reset (RAM is kept)
//   Read, Write           MDR loads RAM[MAR] when MDRin is also set; RAM[MAR] <= MDR
//   IncPC                 with PCin, PC <= PC + 1
//   opcode                reserved, ignored (ALU op always comes from IR[31:27])
//   Gra/Grb/Grc           select IR[26:23] / IR[22:19] / IR[18:15] as register index
//   Rin/Rout/BAout        write / drive / base-address-drive the selected register
//   *in                   register load enables
//   *out, Cout            bus drive enables
//   InPort_input          external input-port data
//   OutPort_output        out-port register
//   CON_out               branch condition flip-flop
//
// The RAM powers up all zero.

module datapath #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 512
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic              IncPC,
    input  logic [4:0]        opcode,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic              BAout,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              Yin,
    input  logic              Zin,
    input  logic              PCin,
    input  logic              IRin,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Inportin,
    input  logic              Outportin,
    input  logic              CONin,
    input  logic              HIout,
    input  logic              LOout,
    input  logic              Yout,
    input  logic              Zhighout,
    input  logic              Zlowout,
    input  logic              PCout,
    input  logic              MARout,
    input  logic              MDRout,
    input  logic              Inportout,
    input  logic              Outportout,
    input  logic              Cout,
    input  logic [DATA_W-1:0] InPort_input,
    output logic [DATA_W-1:0] OutPort_output,
    output logic              CON_out
);

    localparam int unsigned AddrW = $clog2(MEM_DEPTH);
    localparam int unsigned ShW   = $clog2(DATA_W);

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpShr  = 5'b00101;
    localparam logic [4:0] OpShl  = 5'b00110;
    localparam logic [4:0] OpRor  = 5'b00111;
    localparam logic [4:0] OpRol  = 5'b01000;
    localparam logic [4:0] OpAnd  = 5'b01001;
    localparam logic [4:0] OpOr   = 5'b01010;
    localparam logic [4:0] OpAddi = 5'b01011;
    localparam logic [4:0] OpAndi = 5'b01100;
    localparam logic [4:0] OpOri  = 5'b01101;
    localparam logic [4:0] OpMul  = 5'b01110;
    localparam logic [4:0] OpDiv  = 5'b01111;
    localparam logic [4:0] OpNeg  = 5'b10000;
    localparam logic [4:0] OpNot  = 5'b10001;
    localparam logic [4:0] OpBr   = 5'b10010;

    typedef logic [DATA_W-1:0] word_t;

    word_t              regs_q [16];
    word_t              regs_d [16];
    word_t              pc_q, pc_d;
    word_t              ir_q, ir_d;
    word_t              mar_q, mar_d;
    word_t              mdr_q, mdr_d;
    word_t              y_q, y_d;
    word_t              hi_q, hi_d;
    word_t              lo_q, lo_d;
    word_t              inport_q, inport_d;
    word_t              outport_q, outport_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic               con_q, con_d;

    word_t              ram [MEM_DEPTH];
    word_t              ram_rd;

    word_t              bus;
    word_t              c_sext;
    logic [3:0]         reg_idx;

    // The opcode port is reserved; it is folded into an unused net only.
    logic unused_opcode;
    assign unused_opcode = ^opcode;

    initial begin
        for (int unsigned i = 0; i < MEM_DEPTH; i++) ram[i] = '0;
    end

    // Each Gr strobe gates its IR field; the fields are ORed so one strobe picks the register.
    assign reg_idx = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) |
                     ({4{Grc}} & ir_q[18:15]);
    assign c_sext  = {{(DATA_W-19){ir_q[18]}}, ir_q[18:0]};
    assign ram_rd  = ram[mar_q[AddrW-1:0]];

    // Shared bus: fixed-priority mux, zero when nothing drives it.
    always_comb begin
        bus = '0;
        if (Rout)            bus = regs_q[reg_idx];
        else if (BAout)      bus = (reg_idx == 4'd0) ? '0 : regs_q[reg_idx];
        else if (Cout)       bus = c_sext;
        else if (PCout)      bus = pc_q;
        else if (MDRout)     bus = mdr_q;
        else if (Zlowout)    bus = z_q[DATA_W-1:0];
        else if (Zhighout)   bus = z_q[2*DATA_W-1:DATA_W];
        else if (HIout)      bus = hi_q;
        else if (LOout)      bus = lo_q;
        else if (Yout)       bus = y_q;
        else if (MARout)     bus = mar_q;
        else if (Inportout)  bus = inport_q;
        else if (Outportout) bus = outport_q;
    end

    // ALU: A = Y, B = bus, op = IR[31:27].
    logic [ShW-1:0]        sh;
    logic signed [2*DATA_W-1:0] mul_a, mul_b, mul_p;
    word_t                 a_mag, b_mag, q_mag, r_mag, quo, rem;
    word_t                 alu_lo, alu_hi;

    always_comb begin
        sh    = bus[ShW-1:0];
        mul_a = {{DATA_W{y_q[DATA_W-1]}}, y_q};
        mul_b = {{DATA_W{bus[DATA_W-1]}}, bus};
        mul_p = mul_a * mul_b;

        // Signed divide on magnitudes so the most-negative / -1 case just wraps.
        a_mag = y_q[DATA_W-1] ? -y_q : y_q;
        b_mag = bus[DATA_W-1] ? -bus : bus;
        q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
        r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
        quo   = (y_q[DATA_W-1] ^ bus[DATA_W-1]) ? -q_mag : q_mag;
        rem   = y_q[DATA_W-1] ? -r_mag : r_mag;

        alu_hi = '0;
        alu_lo = '0;
        case (ir_q[31:27])
            OpLd, OpLdi, OpSt, OpAdd, OpAddi, OpBr: alu_lo = y_q + bus;
            OpSub:          alu_lo = y_q - bus;
            OpAnd, OpAndi:  alu_lo = y_q & bus;
            OpOr, OpOri:    alu_lo = y_q | bus;
            OpShr:          alu_lo = y_q >> sh;
            OpShl:          alu_lo = y_q << sh;
            // A shift by DATA_W yields zero, so sh = 0 needs no special case.
            OpRor:          alu_lo = (y_q >> sh) | (y_q << (DATA_W - 32'(sh)));
            OpRol:          alu_lo = (y_q << sh) | (y_q >> (DATA_W - 32'(sh)));
            OpMul:          {alu_hi, alu_lo} = mul_p;
            OpDiv: begin
                if (bus != '0) begin
                    alu_hi = rem;
                    alu_lo = quo;
                end
            end
            OpNeg:          alu_lo = -bus;
            OpNot:          alu_lo = ~bus;
            default:        alu_lo = bus;
        endcase
    end

    // Branch condition evaluated on the bus, selected by IR[20:19].
    logic con_cond;
    always_comb begin
        con_cond = 1'b0;
        case (ir_q[20:19])
            2'b00: con_cond = (bus == '0);
            2'b01: con_cond = (bus != '0);
            2'b10: con_cond = ~bus[DATA_W-1];
            2'b11: con_cond = bus[DATA_W-1];
        endcase
    end

    always_comb begin
        regs_d    = regs_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        y_d       = y_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        inport_d  = inport_q;
        outport_d = outport_q;
        z_d       = z_q;
        con_d     = con_q;

        if (Rin)       regs_d[reg_idx] = bus;
        if (Yin)       y_d       = bus;
        if (HIin)      hi_d      = bus;
        if (LOin)      lo_d      = bus;
        if (IRin)      ir_d      = bus;
        if (MARin)     mar_d     = bus;
        if (Outportin) outport_d = bus;
        if (Inportin)  inport_d  = InPort_input;
        if (Zin)       z_d       = {alu_hi, alu_lo};
        if (MDRin)     mdr_d     = Read ? ram_rd : bus;
        if (PCin)      pc_d      = IncPC ? pc_q + word_t'(1) : bus;
        if (CONin)     con_d     = con_cond;
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            z_q       <= '0;
            con_q     <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            y_q       <= y_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
            z_q       <= z_d;
            con_q     <= con_d;
        end
    end

    // RAM captures the MDR value from before this edge, so a coincident MDRin load is not seen.
    always_ff @(posedge Clock) begin
        if (Write && !clear) ram[mar_q[AddrW-1:0]] <= mdr_q;
    end

    assign OutPort_output = outport_q;
    assign CON_out        = con_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    logic        Clock = 1'b0;
    logic        clear, Read, Write, IncPC;
    logic [4:0]  opcode;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Outportin, CONin;
    logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, MARout, MDRout;
    logic        Inportout, Outportout, Cout;
    logic [31:0] InPort_input;
    logic [31:0] OutPort_output;
    logic        CON_out;

    datapath dut (
        .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .IncPC(IncPC),
        .opcode(opcode), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin),
        .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin),
        .Outportin(Outportin), .CONin(CONin), .HIout(HIout), .LOout(LOout), .Yout(Yout),
        .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout), .MARout(MARout),
        .MDRout(MDRout), .Inportout(Inportout), .Outportout(Outportout), .Cout(Cout),
        .InPort_input(InPort_input), .OutPort_output(OutPort_output), .CON_out(CON_out)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [31:0] m_r [16];
    logic [31:0] m_ram [512];
    logic [31:0] m_pc, m_mdr, m_hi, m_lo, m_y, m_mar;
    logic [63:0] m_z;

    // Reference ALU straight from the instruction definitions, using 64-bit integer math.
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] t;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        n  = int'(b[4:0]);
        t  = a;
        case (op)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd11, 5'd18: return {32'd0, a + b};
            5'd4:        return {32'd0, a - b};
            5'd9, 5'd12: return {32'd0, a & b};
            5'd10, 5'd13: return {32'd0, a | b};
            5'd5:        return {32'd0, a >> n};
            5'd6:        return {32'd0, a << n};
            5'd7: begin
                repeat (n) t = {t[0], t[31:1]};
                return {32'd0, t};
            end
            5'd8: begin
                repeat (n) t = {t[30:0], t[31]};
                return {32'd0, t};
            end
            5'd14:       return sa * sb;
            5'd15: begin
                if (sb == 0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            5'd16:       return {32'd0, -b};
            5'd17:       return {32'd0, ~b};
            default:     return {32'd0, b};
        endcase
    endfunction

    function automatic logic ref_con(input logic [1:0] sel, input logic [31:0] v);
        case (sel)
            2'b00:   return v == 32'd0;
            2'b01:   return v != 32'd0;
            2'b10:   return !v[31];
            default: return v[31];
        endcase
    endfunction

    task automatic idle();
        clear = 0; Read = 0; Write = 0; IncPC = 0; opcode = 5'd0;
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        HIin = 0; LOin = 0; Yin = 0; Zin = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0;
        Inportin = 0; Outportin = 0; CONin = 0;
        HIout = 0; LOout = 0; Yout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MARout = 0;
        MDRout = 0; Inportout = 0; Outportout = 0; Cout = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller has already raised the bus source; latch the bus into the out-port and compare.
    task automatic observe(input string tag, input logic [31:0] exp);
        Outportin = 1;
        tick();
        check(tag, OutPort_output, exp);
    endtask

    task automatic load_in(input logic [31:0] v);
        InPort_input = v;
        Inportin = 1;
        tick();
    endtask

    task automatic set_ir(input logic [31:0] v);
        load_in(v);
        Inportout = 1; IRin = 1;
        tick();
    endtask

    task automatic set_y(input logic [31:0] v);
        load_in(v);
        Inportout = 1; Yin = 1;
        tick();
        m_y = v;
    endtask

    task automatic write_reg(input logic [3:0] i, input logic [31:0] v);
        set_ir({5'd0, i, 23'd0});
        load_in(v);
        Inportout = 1; Gra = 1; Rin = 1;
        tick();
        m_r[i] = v;
    endtask

    task automatic read_reg(input logic [3:0] i, input string tag);
        set_ir({5'd0, i, 23'd0});
        Gra = 1; Rout = 1;
        observe(tag, m_r[i]);
    endtask

    task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        set_y(a);
        set_ir({op, 27'd0});
        load_in(b);
        Inportout = 1; Zin = 1;
        tick();
        m_z = ref_alu(op, a, b);
        Zlowout = 1;
        observe({tag, "_lo"}, m_z[31:0]);
        Zhighout = 1;
        observe({tag, "_hi"}, m_z[63:32]);
    endtask

    task automatic ram_write(input logic [8:0] addr, input logic [31:0] v);
        load_in({23'd0, addr});
        Inportout = 1; MARin = 1;
        tick();
        load_in(v);
        Inportout = 1; MDRin = 1;
        tick();
        Write = 1;
        tick();
        m_ram[addr] = v;
        m_mar = {23'd0, addr};
        m_mdr = v;
    endtask

    task automatic ram_read_check(input logic [8:0] addr, input string tag);
        load_in({23'd0, addr});
        Inportout = 1; MARin = 1;
        tick();
        MDRin = 1; Read = 1;
        tick();
        MDRout = 1;
        observe(tag, m_ram[addr]);
    endtask

    logic [31:0] va, vb, r3v;
    logic [4:0]  op;
    logic [1:0]  sel;
    logic [3:0]  idx;
    logic [8:0]  addr;

    initial begin
        idle();
        InPort_input = 32'd0;
        for (int i = 0; i < 16; i++) m_r[i] = 32'd0;

        // Fill state with non-zero values so the reset has something to clear.
        for (int i = 0; i < 16; i++) write_reg(i[3:0], $urandom | 32'h1);
        load_in(32'h100);
        Inportout = 1; PCin = 1;
        tick();
        set_y(32'd5);
        load_in(32'd3);
        Inportout = 1; Zin = 1; HIin = 1;
        tick();
        set_ir(32'h000F_FFFF);
        load_in(32'd1);
        Inportout = 1; CONin = 1; Outportin = 1;
        tick();
        check("con_preload", {31'd0, CON_out}, 32'd1);

        // Reset with loads asserted at the same time; clear must win.
        clear = 1; Inportout = 1; PCin = 1; IncPC = 1; Yin = 1; Zin = 1; Rin = 1; Gra = 1;
        CONin = 1; IRin = 1;
        tick();
        for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
        m_pc = 0; m_mdr = 0; m_hi = 0; m_lo = 0; m_y = 0; m_mar = 0; m_z = 0;
        check("rst_outport", OutPort_output, 32'd0);
        check("rst_con", {31'd0, CON_out}, 32'd0);
        Inportout = 1; observe("rst_inport", 32'd0);
        PCout = 1;     observe("rst_pc", 32'd0);
        Cout = 1;      observe("rst_ir", 32'd0);
        Zlowout = 1;   observe("rst_zlo", 32'd0);
        Zhighout = 1;  observe("rst_zhi", 32'd0);
        Yout = 1;      observe("rst_y", 32'd0);
        HIout = 1;     observe("rst_hi", 32'd0);
        for (int i = 0; i < 16; i++) read_reg(i[3:0], $sformatf("rst_r%0d", i));

        // Fetch of andi R2, R1, 5 from RAM[0]
        ram_write(9'd0, 32'h6108_0005);
        write_reg(4'd1, 32'h0000_000C);
        PCout = 1; MARin = 1;                     tick();
        MDRin = 1; Read = 1;                      tick();
        MDRout = 1; IRin = 1; PCin = 1; IncPC = 1; tick();
        m_pc = 32'd1;
        PCout = 1;  observe("fetch_pc", m_pc);
        MDRout = 1; observe("fetch_mdr", 32'h6108_0005);
        Cout = 1;   observe("fetch_ir_c", 32'h0000_0005);
        // Execute
        Grb = 1; Rout = 1; Yin = 1;   tick();
        Cout = 1; Zin = 1;            tick();
        Zlowout = 1; Gra = 1; Rin = 1; tick();
        m_r[2] = ref_alu(5'b01100, m_r[1], 32'd5);
        read_reg(4'd2, "andi_r2");
        read_reg(4'd1, "andi_r1");

        // Divide, including divide by zero
        alu_run(5'b01111, 32'd7, 32'hFFFF_FFFE, "div");
        alu_run(5'b01111, 32'd7, 32'd0, "div0");
        alu_run(5'b01111, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");

        // Branch condition: directed corners then random
        for (int k = 0; k < 14; k++) begin
            case (k)
                0: begin sel = 2'b01; va = 32'd5; end
                1: begin sel = 2'b00; va = 32'd5; end
                2: begin sel = 2'b00; va = 32'd0; end
                3: begin sel = 2'b10; va = 32'h8000_0000; end
                4: begin sel = 2'b11; va = 32'h8000_0000; end
                5: begin sel = 2'b10; va = 32'd7; end
                default: begin
                    sel = 2'($urandom_range(0, 3));
                    va  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                end
            endcase
            set_ir({11'd0, sel, 19'd0});
            load_in(va);
            Inportout = 1; CONin = 1;
            tick();
            check($sformatf("con_sel%0d_%h", sel, va), {31'd0, CON_out},
                  {31'd0, ref_con(sel, va)});
        end

        // Ports
        load_in(32'h0000_00A5);
        Inportout = 1; Outportin = 1;
        tick();
        check("port_a5", OutPort_output, 32'h0000_00A5);

        // PC increment wraps
        load_in(32'hFFFF_FFFF);
        Inportout = 1; PCin = 1;  tick();
        PCin = 1; IncPC = 1;      tick();
        m_pc = 32'd0;
        PCout = 1; observe("pc_wrap", m_pc);

        // Bus priority, every source holding a distinct value
        r3v = $urandom;
        write_reg(4'd3, r3v);
        alu_run(5'b01110, $urandom, $urandom, "mul_prio");
        m_hi = $urandom;  load_in(m_hi);  Inportout = 1; HIin = 1;  tick();
        m_lo = $urandom;  load_in(m_lo);  Inportout = 1; LOin = 1;  tick();
        m_mar = $urandom; load_in(m_mar); Inportout = 1; MARin = 1; tick();
        m_mdr = $urandom; load_in(m_mdr); Inportout = 1; MDRin = 1; tick();
        m_pc = $urandom;  load_in(m_pc);  Inportout = 1; PCin = 1;  tick();
        set_y($urandom);
        set_ir(32'h0180_7FFF);
        Gra = 1; Rout = 1; Cout = 1; PCout = 1;  observe("prio_rout", r3v);
        Gra = 1; BAout = 1; Cout = 1;            observe("prio_baout", r3v);
        Cout = 1; PCout = 1;                     observe("prio_cout", 32'h0000_7FFF);
        PCout = 1; MDRout = 1;                   observe("prio_pc", m_pc);
        MDRout = 1; Zlowout = 1;                 observe("prio_mdr", m_mdr);
        Zlowout = 1; Zhighout = 1; HIout = 1;    observe("prio_zlo", m_z[31:0]);
        Zhighout = 1; HIout = 1;                 observe("prio_zhi", m_z[63:32]);
        HIout = 1; LOout = 1;                    observe("prio_hi", m_hi);
        LOout = 1; Yout = 1;                     observe("prio_lo", m_lo);
        Yout = 1; MARout = 1;                    observe("prio_y", m_y);
        MARout = 1; Inportout = 1;               observe("prio_mar", m_mar);
        Inportout = 1; Outportout = 1;           observe("prio_inport", 32'h0180_7FFF);

        // BAout reads zero for index 0; R0 is otherwise an ordinary register
        write_reg(4'd0, 32'hDEAD_BEEF);
        set_ir(32'd0);
        Gra = 1; BAout = 1; observe("baout_r0", 32'd0);
        Gra = 1; Rout = 1;  observe("rout_r0", m_r[0]);

        // Write coinciding with an MDR load stores the old MDR
        va = $urandom; vb = $urandom;
        ram_write(9'd9, va);
        load_in(vb);
        Inportout = 1; MDRin = 1; Write = 1;
        tick();
        MDRout = 1; observe("wr_mdr_new", vb);
        ram_read_check(9'd9, "wr_ram_old");

        // Random ALU operations
        for (int k = 0; k < 30; k++) begin
            op = 5'($urandom_range(0, 31));
            va = $urandom;
            vb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) - 32'd8 : $urandom;
            alu_run(op, va, vb, $sformatf("alu_op%0d", op));
        end

        // Random register file and RAM traffic
        for (int k = 0; k < 10; k++) begin
            idx = 4'($urandom_range(0, 15));
            write_reg(idx, $urandom);
            read_reg(idx, $sformatf("reg_w%0d", idx));
            read_reg(idx ^ 4'd5, $sformatf("reg_o%0d", idx ^ 4'd5));
        end
        for (int k = 0; k < 6; k++) begin
            addr = 9'($urandom_range(1, 511));
            ram_write(addr, $urandom);
            ram_write(addr ^ 9'h100, $urandom);
            ram_read_check(addr, $sformatf("ram_%0d", addr));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
